// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - idle-driven clock-gate enable controller with wake handshake
// Gates the downstream clock after a sustained idle window and re-enables it on demand.
module clk_gate_ctrl #(
  parameter int unsigned IdleCycles = 16,
  parameter int unsigned WakeCycles = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        busy_i,
  input  logic        req_i,
  input  logic        force_en_i,
  output logic        clk_en_o,
  output logic        ack_o,
  output logic        gated_o,
  output logic [15:0] gate_cnt_o
);

  localparam int unsigned MaxCycles = (IdleCycles > WakeCycles) ? IdleCycles : WakeCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] IdleLoad = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0] WakeLoad = CntW'(WakeCycles - 1);

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    GATED,
    WAKE
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     gate_cnt_q, gate_cnt_d;
  logic            wake_req;

  assign wake_req = busy_i | req_i | force_en_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ACTIVE;
      cnt_q      <= '0;
      gate_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gate_cnt_q <= gate_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gate_cnt_d = gate_cnt_q;
    unique case (state_q)
      ACTIVE: begin
        if (!wake_req) begin
          state_d = DRAIN;
          cnt_d   = IdleLoad;
        end
      end
      DRAIN: begin
        // Any activity during the drain window restarts the full idle count.
        if (wake_req) begin
          state_d = ACTIVE;
        end else if (cnt_q == '0) begin
          state_d = GATED;
          if (gate_cnt_q != 16'hFFFF) begin
            gate_cnt_d = gate_cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      GATED: begin
        if (wake_req) begin
          state_d = WAKE;
          cnt_d   = WakeLoad;
        end
      end
      WAKE: begin
        // Wake always runs to completion so the clock settles before ack.
        if (cnt_q == '0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clk_en_o   = (state_q != GATED);
  assign ack_o      = (state_q == ACTIVE) || (state_q == DRAIN);
  assign gated_o    = (state_q == GATED);
  assign gate_cnt_o = gate_cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - directed self-checking bench for clk_gate_ctrl
// Inputs change and outputs are sampled on the falling edge; IdleCycles=4, WakeCycles=2.
module tb_clk_gate_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        busy_i = 1'b0;
  logic        req_i = 1'b0;
  logic        force_en_i = 1'b0;
  logic        clk_en_o;
  logic        ack_o;
  logic        gated_o;
  logic [15:0] gate_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  clk_gate_ctrl #(
    .IdleCycles(4),
    .WakeCycles(2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .busy_i     (busy_i),
    .req_i      (req_i),
    .force_en_i (force_en_i),
    .clk_en_o   (clk_en_o),
    .ack_o      (ack_o),
    .gated_o    (gated_o),
    .gate_cnt_o (gate_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    busy_i = 1'b0; req_i = 1'b0; force_en_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    busy_i = 1'b0; req_i = 1'b0; force_en_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({clk_en_o, ack_o, gated_o} !== 3'b110) begin
      n_fail++; $display("FAIL reset_outs: got %b want 110", {clk_en_o, ack_o, gated_o});
    end
    n_checks++;
    if (gate_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_gate_cnt: got %h want 0000", gate_cnt_o);
    end
    rst_i = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (clk_en_o !== (e < 5)) begin
        n_fail++; $display("FAIL reset_idle_clk_en edge %0d: got %b want %b", e, clk_en_o, (e < 5));
      end
    end
    n_checks++;
    if ({ack_o, gated_o, gate_cnt_o} !== {1'b0, 1'b1, 16'd1}) begin
      n_fail++; $display("FAIL reset_gated: ack=%b gated=%b cnt=%h want ack=0 gated=1 cnt=0001", ack_o, gated_o, gate_cnt_o);
    end
  endtask

  task automatic test_abort();
    do_reset();
    repeat (3) tick();
    busy_i = 1'b1;
    tick();
    busy_i = 1'b0;
    n_checks++;
    if ({clk_en_o, ack_o} !== 2'b11) begin
      n_fail++; $display("FAIL abort_active: got %b want 11", {clk_en_o, ack_o});
    end
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (clk_en_o !== (e < 5)) begin
        n_fail++; $display("FAIL abort_clk_en edge %0d: got %b want %b", e, clk_en_o, (e < 5));
      end
    end
    repeat (3) tick();
    n_checks++;
    if ({gated_o, gate_cnt_o} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL abort_gate_cnt: gated=%b cnt=%h want gated=1 cnt=0001", gated_o, gate_cnt_o);
    end
  endtask

  task automatic test_wake();
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    n_checks++;
    if ({clk_en_o, ack_o, gated_o} !== 3'b100) begin
      n_fail++; $display("FAIL wake_first_edge: got %b want 100", {clk_en_o, ack_o, gated_o});
    end
    tick();
    n_checks++;
    if ({clk_en_o, ack_o} !== 2'b10) begin
      n_fail++; $display("FAIL wake_second_edge: got %b want 10", {clk_en_o, ack_o});
    end
    tick();
    n_checks++;
    if ({clk_en_o, ack_o} !== 2'b11) begin
      n_fail++; $display("FAIL wake_ack: got %b want 11", {clk_en_o, ack_o});
    end
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (ack_o !== (e < 5)) begin
        n_fail++; $display("FAIL wake_ack_hold edge %0d: got %b want %b", e, ack_o, (e < 5));
      end
    end
    n_checks++;
    if ({gated_o, gate_cnt_o} !== {1'b1, 16'd2}) begin
      n_fail++; $display("FAIL wake_regate: gated=%b cnt=%h want gated=1 cnt=0002", gated_o, gate_cnt_o);
    end
  endtask

  task automatic test_force();
    int bad;
    do_reset();
    force_en_i = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (clk_en_o !== 1'b1 || gated_o !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL force_hold: %0d cycles lost enable, want 0", bad);
    end
    n_checks++;
    if (gate_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL force_gate_cnt: got %h want 0000", gate_cnt_o);
    end
    force_en_i = 1'b0;
    repeat (5) tick();
    n_checks++;
    if ({clk_en_o, gated_o, gate_cnt_o} !== {1'b0, 1'b1, 16'd1}) begin
      n_fail++; $display("FAIL force_gate: en=%b gated=%b cnt=%h want en=0 gated=1 cnt=0001", clk_en_o, gated_o, gate_cnt_o);
    end
    force_en_i = 1'b1;
    tick();
    force_en_i = 1'b0;
    n_checks++;
    if ({clk_en_o, ack_o} !== 2'b10) begin
      n_fail++; $display("FAIL force_wake_en: got %b want 10", {clk_en_o, ack_o});
    end
    repeat (2) tick();
    n_checks++;
    if ({clk_en_o, ack_o} !== 2'b11) begin
      n_fail++; $display("FAIL force_wake_ack: got %b want 11", {clk_en_o, ack_o});
    end
  endtask

  task automatic test_saturation();
    force dut.gate_cnt_q = 16'hFFFE;
    #1;
    release dut.gate_cnt_q;
    n_checks++;
    if (gate_cnt_o !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_preload: got %h want fffe", gate_cnt_o);
    end
    @(negedge clk_i);
    repeat (5) tick();
    n_checks++;
    if ({gated_o, gate_cnt_o} !== {1'b1, 16'hFFFF}) begin
      n_fail++; $display("FAIL sat_first: gated=%b cnt=%h want gated=1 cnt=ffff", gated_o, gate_cnt_o);
    end
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    repeat (2) tick();
    repeat (5) tick();
    n_checks++;
    if ({gated_o, gate_cnt_o} !== {1'b1, 16'hFFFF}) begin
      n_fail++; $display("FAIL sat_hold: gated=%b cnt=%h want gated=1 cnt=ffff", gated_o, gate_cnt_o);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (5) tick();
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    n_checks++;
    if ({clk_en_o, ack_o, gated_o, gate_cnt_o} !== {3'b110, 16'd0}) begin
      n_fail++; $display("FAIL mid_wake_reset: en=%b ack=%b gated=%b cnt=%h want 1 1 0 0000", clk_en_o, ack_o, gated_o, gate_cnt_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) tick();
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    repeat (2) tick();
    repeat (2) tick();
    n_checks++;
    if ({clk_en_o, ack_o, gate_cnt_o} !== {2'b11, 16'd1}) begin
      n_fail++; $display("FAIL mid_drain_pre: en=%b ack=%b cnt=%h want 1 1 0001", clk_en_o, ack_o, gate_cnt_o);
    end
    #1 rst_i = 1'b1;
    #1;
    n_checks++;
    if ({clk_en_o, ack_o, gated_o, gate_cnt_o} !== {3'b110, 16'd0}) begin
      n_fail++; $display("FAIL mid_drain_reset: en=%b ack=%b gated=%b cnt=%h want 1 1 0 0000", clk_en_o, ack_o, gated_o, gate_cnt_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (clk_en_o !== (e < 5)) begin
        n_fail++; $display("FAIL mid_reset_window edge %0d: got %b want %b", e, clk_en_o, (e < 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_wake();
    test_force();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 The block SHALL have parameter IdleCycles, int unsigned, default 16, range >=1: the number of consecutive idle samples, after the first, before gating.
REQ-002 The block SHALL have parameter WakeCycles, int unsigned, default 2, range >=1: the number of enabled-clock cycles before acknowledge.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the free-running, ungated clock. The whole block is clocked on rising edges.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port busy_i, input, 1 bit: the gated domain reports activity.
REQ-006 The block SHALL have port req_i, input, 1 bit: a level-type wake/stay-awake request from a consumer.
REQ-007 The block SHALL have port force_en_i, input, 1 bit: a force clock-enable override (test/debug).
REQ-008 The block SHALL have port clk_en_o, output, 1 bit: the enable to the downstream ICG en_i.
REQ-009 The block SHALL have port ack_o, output, 1 bit: indicates that the gated clock is running and stable.
REQ-010 The block SHALL have port gated_o, output, 1 bit: status, asserted while in the GATED state.
REQ-011 The block SHALL have port gate_cnt_o, output, 16 bits: a saturating count of entries into GATED.

Function
REQ-012 The block SHALL define idle as busy_i==0 && req_i==0 && force_en_i==0, sampled on each rising edge.
REQ-013 The block SHALL implement FSM states ACTIVE, DRAIN, GATED and WAKE, plus an internal down-counter cnt sized $clog2(max(IdleCycles,WakeCycles)+1).
REQ-014 All outputs SHALL be registered Moore outputs decoded from the state.
- clk_en_o = 1 in ACTIVE, DRAIN and WAKE; 0 in GATED.
- ack_o = 1 in ACTIVE and DRAIN only.
- gated_o = 1 in GATED only.
REQ-015 In ACTIVE: if idle, the next state SHALL be DRAIN with cnt loaded to IdleCycles-1; otherwise the FSM SHALL stay in ACTIVE.
REQ-016 In DRAIN:
- not idle -> ACTIVE (abort, no gating);
- idle && cnt==0 -> GATED;
- otherwise cnt decrements.
REQ-017 Consequently, clk_en_o SHALL fall after the (IdleCycles+1)-th consecutive idle sample, and any non-idle sample restarts the full idle window.
REQ-018 On each DRAIN->GATED transition, gate_cnt_o SHALL increment by 1 and saturate at 16'hFFFF with no wrap.
REQ-019 In GATED: if busy_i || req_i || force_en_i, the next state SHALL be WAKE with cnt loaded to WakeCycles-1; otherwise the FSM SHALL stay in GATED.
REQ-020 Consequently, clk_en_o SHALL rise on the edge following the first wake sample.
REQ-021 In WAKE: if cnt==0, the next state SHALL be ACTIVE; otherwise cnt decrements. WAKE SHALL ignore all inputs and SHALL NOT abort back to GATED.
REQ-022 ack_o SHALL rise WakeCycles+1 edges after the wake sample.
REQ-023 When idle and a wake condition are evaluated simultaneously, the wake condition SHALL take priority, since idle requires all wake inputs to be low.
REQ-024 force_en_i=1 SHALL keep the FSM out of GATED indefinitely; asserted in GATED, it SHALL wake the block exactly as req_i does.
REQ-025 The block SHALL NOT contain any combinational path from inputs to outputs.

Reset
REQ-026 While rst_i is high, the state SHALL be ACTIVE, cnt SHALL be 0 and gate_cnt_o SHALL be 0, applied asynchronously. Outputs during reset: clk_en_o=1, ack_o=1, gated_o=0.
REQ-027 Reset asserted in any state, including mid-DRAIN or mid-WAKE, SHALL immediately force ACTIVE values, with no partial count retained.
REQ-028 Reset release SHALL be synchronous to clk_i. The first rising edge after release SHALL evaluate ACTIVE normally.

Verification (IdleCycles=4, WakeCycles=2)
REQ-029 Reset gating scenario: hold rst_i, then release with all inputs 0 -> clk_en_o stays 1 for the first 5 idle edges, falls after edge 5; gated_o=1; gate_cnt_o=1.
REQ-030 Abort scenario: idle for 3 edges, then busy_i=1 for 1 edge, then idle again -> no gating until 5 further consecutive idle edges; gate_cnt_o increments only once.
REQ-031 Wake scenario: in GATED, pulse req_i high for 1 cycle -> clk_en_o=1 after the next edge, ack_o=1 three edges after the sample; ack_o stays 1 after req_i drops until a new 5-edge idle window completes.
REQ-032 Force scenario: force_en_i=1 for 100 cycles with busy_i=0 and req_i=0 -> clk_en_o stays 1 and gate_cnt_o is unchanged; asserting force_en_i in GATED wakes the block as in the wake scenario.
REQ-033 Saturation scenario: preload via 65537 gate/wake cycles, or force the counter to 16'hFFFE, then gate twice -> gate_cnt_o = 16'hFFFF and holds.
REQ-034 Mid-operation reset scenario: assert rst_i asynchronously mid-WAKE (cnt=1) and mid-DRAIN -> outputs immediately become clk_en_o=1, ack_o=1, gated_o=0, gate_cnt_o=0, with no clock edge required.
